// File: rtl/fft_frame_loader.sv
// fft_frame_loader
//   Upstream feeder for the FFT butterfly loop. Real audio samples (IEEE-754
//   doubles) arrive on a valid/ready handshake. Arrival index k is stored
//   unmodified at bit-reversed position bitrev(k) of an N-entry frame. Imaginary
//   parts are always zero. A full frame is presented to the loop by raising
//   FftStart and is held stable until the loop reports done.
//
// Ports
//   Clock        rising-edge clock
//   Areset       asynchronous active-low reset
//   SampleIn     real sample (DW bits, stored as-is)
//   SampleValid  SampleIn valid this cycle
//   SampleReady  loader accepts SampleIn this cycle (depends on state only)
//   FftDone      level from the loop, high while the loop sits in its done state
//   FftStart     level to the loop In: frame ready, compute
//   KgrpsReal    presented frame real parts, bit-reversed order
//   KgrpsImag    presented frame imaginary parts, constant zero
//   FrameCount   frames handed to the FFT, wraps 16'hFFFF -> 0
//
// Configuration
//   FFT_LOADER_DOUBLE_BUF_EN  defined: ping-pong capture/presentation banks so
//                             capture continues while the FFT owns a frame.
//                             undefined: single bank, samples back-pressured
//                             while the FFT owns the frame.

module fft_frame_loader #(
  parameter int unsigned N    = 16,
  parameter int unsigned LOGN = 4,
  parameter int unsigned DW   = 64
) (
  input  logic                  Clock,
  input  logic                  Areset,
  input  logic [DW-1:0]         SampleIn,
  input  logic                  SampleValid,
  output logic                  SampleReady,
  input  logic                  FftDone,
  output logic                  FftStart,
  output logic [N-1:0][DW-1:0]  KgrpsReal,
  output logic [N-1:0][DW-1:0]  KgrpsImag,
  output logic [15:0]           FrameCount
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    ARMED   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] k);
    logic [LOGN-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOGN; i++) begin
      r[i] = k[LOGN-1-i];
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [LOGN-1:0] idx_q, idx_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            start_q, start_d;
  logic            xfer;

  assign xfer        = SampleValid & ready_q;
  assign SampleReady = ready_q;
  assign FftStart    = start_q;
  assign FrameCount  = cnt_q;
  assign KgrpsImag   = '0;

`ifndef FFT_LOADER_DOUBLE_BUF_EN

  logic [N-1:0][DW-1:0] frame_q, frame_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    case (state_q)
      FILL: begin
        // FftDone seen here is a stale level from the previous frame.
        if (xfer) begin
          frame_d[bitrev(idx_q)] = SampleIn;
          idx_d                  = idx_q + LOGN'(1);
          if (idx_q == LAST_IDX) begin
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (FftDone) begin
          state_d = RELEASE;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      RELEASE: begin
        if (!FftDone) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    // Outputs registered from the next state so they are pure state functions.
    ready_d = (state_d == FILL);
    start_d = (state_d == ARMED);
  end

  assign KgrpsReal = frame_q;

  always_ff @(posedge Clock or negedge Areset) begin
    if (!Areset) begin
      state_q <= FILL;
      idx_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      start_q <= start_d;
      frame_q <= frame_d;
    end
  end

`else

  logic [N-1:0][DW-1:0] bank_q [2];
  logic [N-1:0][DW-1:0] bank_d [2];
  logic                 cap_bank_q, cap_bank_d;
  logic                 pres_bank_q, pres_bank_d;
  logic                 cap_full_q, cap_full_d;
  logic                 last_xfer;

  // state_q tracks the presented bank: FILL means nothing is owned by the FFT
  // (capture and presentation may share a bank), ARMED/RELEASE mean the
  // presented bank belongs to the FFT and capture runs in the other bank.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    bank_d      = bank_q;
    cap_bank_d  = cap_bank_q;
    pres_bank_d = pres_bank_q;
    cap_full_d  = cap_full_q;
    last_xfer   = xfer && (idx_q == LAST_IDX);

    if (xfer) begin
      bank_d[cap_bank_q][bitrev(idx_q)] = SampleIn;
      idx_d                             = idx_q + LOGN'(1);
    end

    case (state_q)
      FILL: begin
        // cap_full_q here only when the capture bank completed on the same
        // edge that RELEASE ended; hand it over one cycle later.
        if (last_xfer || cap_full_q) begin
          state_d     = ARMED;
          pres_bank_d = cap_bank_q;
          cap_bank_d  = ~cap_bank_q;
          cap_full_d  = 1'b0;
        end
      end
      ARMED: begin
        if (last_xfer) begin
          cap_full_d = 1'b1;
        end
        if (FftDone) begin
          state_d = RELEASE;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      RELEASE: begin
        if (last_xfer) begin
          cap_full_d = 1'b1;
        end
        if (!FftDone) begin
          if (cap_full_q) begin
            state_d     = ARMED;
            pres_bank_d = cap_bank_q;
            cap_bank_d  = ~cap_bank_q;
            cap_full_d  = 1'b0;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase

    ready_d = ~cap_full_d;
    start_d = (state_d == ARMED);
  end

  assign KgrpsReal = bank_q[pres_bank_q];

  always_ff @(posedge Clock or negedge Areset) begin
    if (!Areset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      start_q     <= 1'b0;
      bank_q      <= '{default: '0};
      cap_bank_q  <= 1'b0;
      pres_bank_q <= 1'b0;
      cap_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      start_q     <= start_d;
      bank_q      <= bank_d;
      cap_bank_q  <= cap_bank_d;
      pres_bank_q <= pres_bank_d;
      cap_full_q  <= cap_full_d;
    end
  end

`endif

endmodule
